mem_lsu_ctrl: RTL and testbench
===============================

Name: mem_lsu_ctrl

Overview:
- Load/store sequencer between the core execute stage and the single-port data memory.
- Accepts one RV32I load/store request at a time and checks alignment.
- Generates the word address, byte enables and write-lane replication for the memory.
- Returns sign/zero-extended load data or store completion through a valid/ready response port.

Parameters:
B_WIDTH, 32, data bus width; only 32 supported (RV32I).
MEM_SIZE, 10, data memory word-address width; memory holds 2**MEM_SIZE words.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  request present
req_ready  output  1  controller can accept request
req_we  input  1  1=store, 0=load
req_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
req_addr  input  B_WIDTH  byte address
req_wdata  input  B_WIDTH  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  B_WIDTH  extended load data; 0 for stores and errors
resp_err  output  1  misaligned, illegal-funct3 or out-of-range request
mem_addr  output  MEM_SIZE  word address = req_addr[MEM_SIZE+1:2]
mem_read_en  output  1  memory read strobe
mem_write_en  output  1  memory write strobe
write_byte_en  output  B_WIDTH/8  byte-lane write enables
mem_wdata  output  B_WIDTH  lane-replicated store data
mem_rdata  input  B_WIDTH  memory read data, valid the cycle after mem_read_en

Behaviour:
- Reset: state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read_en=mem_write_en=0; write_byte_en=0; mem_addr=0; mem_wdata=0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- req_ready=1 only in IDLE.
- Accept occurs on req_valid&req_ready. On accept, addr, funct3, we and wdata are registered.
- Error check at accept. resp_err is set when any of these holds:
  - funct3 is not in the legal set.
  - Store funct3 is 100 or 101.
  - Halfword request with addr[0]!=0.
  - Word request with addr[1:0]!=0.
- Error path: IDLE->RESP with resp_err=1 and resp_rdata=0. No mem strobe is ever asserted.
- Store path: IDLE->ACCESS (mem_write_en=1 for exactly one cycle) ->RESP.
  - Byte: write_byte_en=1<<addr[1:0], wdata[7:0] replicated x4.
  - Half: write_byte_en=0011 or 1100 by addr[1], wdata[15:0] replicated x2.
  - Word: write_byte_en=1111.
- Load path: IDLE->ACCESS (mem_read_en=1, one cycle) ->WAIT ->RESP.
  - In WAIT, sample mem_rdata and select the byte/half by addr[1:0].
  - Sign-extend for LB/LH; zero-extend for LBU/LHU.
  - Register the result into resp_rdata.
- mem_read_en and mem_write_en are never asserted in the same cycle. write_byte_en=0 whenever mem_write_en=0.
- Latency from accept cycle T, with resp_ready held high:
  - Load: resp_valid first high at T+3.
  - Store: resp_valid first high at T+2.
  - Error: resp_valid first high at T+1.
- RESP handling:
  - resp_valid, resp_rdata and resp_err stay stable while resp_ready=0.
  - On resp_valid&resp_ready, return to IDLE. resp_valid drops the next cycle.
  - req_ready rises the next cycle; no same-cycle bypass.
- Requests arriving while not in IDLE are ignored (req_ready=0). The requester holds them.
- rst asserted in any state returns everything to reset values on the next edge.
  - An in-flight access is abandoned.
  - A store in ACCESS when rst rises still has its strobe sampled by memory that edge. This is acceptable.

Optional Feature:
- Macro: MEM_LSU_BOUND_CHK_EN.
- Defined: any nonzero bit in req_addr[B_WIDTH-1:MEM_SIZE+2] raises resp_err through the error path; no memory access occurs.
- Undefined: upper address bits are ignored and the address wraps modulo 2**(MEM_SIZE+2) bytes.

Test Plan:
- Reset mid-load:
  - Stimulus: rst=1 for 2 cycles, then LW at 0x10; in the following cycle rst=1.
  - Required: all outputs at reset values, req_ready=1, resp_valid never rises.
- SW then LW round trip:
  - Stimulus: SW 0xDEADBEEF to 0x20, then LW from 0x20.
  - Required: write_byte_en=1111, mem_addr=0x08, one-cycle mem_write_en, resp_valid at T+2.
  - Required on load: resp_rdata=0xDEADBEEF at T+3, resp_err=0.
- Byte store and sign/zero extension:
  - Stimulus: SB 0x80 to 0x23, then LB and LBU at 0x23.
  - Required: write_byte_en=1000, mem_wdata=0x80808080.
  - Required: LB returns 0xFFFFFF80, LBU returns 0x00000080.
- Misaligned and illegal requests:
  - Stimulus: LH at 0x21, SW at 0x22, store with funct3=100.
  - Required: resp_err=1 at T+1, resp_rdata=0, mem_read_en/mem_write_en never asserted.
- Response backpressure:
  - Stimulus: LHU at 0x22 (memory word 0x1234ABCD) with resp_ready=0 for 5 cycles.
  - Required: resp_valid held, resp_rdata=0x00001234 stable, req_ready=0.
  - Required after resp_ready=1: IDLE next cycle.
- Out-of-range address (MEM_SIZE=10):
  - Stimulus: LW at 0x1000.
  - With MEM_LSU_BOUND_CHK_EN: resp_err=1, no strobe.
  - Without the macro: read of word 0, resp_err=0.

Source files
------------

// File: rtl/mem_lsu_ctrl.sv
// RV32I load/store sequencer: one request at a time, alignment check, lane steering, extended load return.
// Optional MEM_LSU_BOUND_CHK_EN turns nonzero upper address bits into an error instead of wrapping.
module mem_lsu_ctrl #(
  parameter int B_WIDTH  = 32,
  parameter int MEM_SIZE = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [2:0]             req_funct3,
  input  logic [B_WIDTH-1:0]     req_addr,
  input  logic [B_WIDTH-1:0]     req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [B_WIDTH-1:0]     resp_rdata,
  output logic                   resp_err,
  output logic [MEM_SIZE-1:0]    mem_addr,
  output logic                   mem_read_en,
  output logic                   mem_write_en,
  output logic [B_WIDTH/8-1:0]   write_byte_en,
  output logic [B_WIDTH-1:0]     mem_wdata,
  input  logic [B_WIDTH-1:0]     mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;

  state_t                 state_q;
  logic [1:0]             addr_q;
  logic [2:0]             funct3_q;
  logic                   we_q;
  logic                   req_ready_q, resp_valid_q, resp_err_q;
  logic [B_WIDTH-1:0]     resp_rdata_q;
  logic                   mem_read_en_q, mem_write_en_q;
  logic [MEM_SIZE-1:0]    mem_addr_q;
  logic [B_WIDTH/8-1:0]   be_q;
  logic [B_WIDTH-1:0]     mem_wdata_q;

  logic out_of_range;
`ifdef MEM_LSU_BOUND_CHK_EN
  assign out_of_range = |req_addr[B_WIDTH-1:MEM_SIZE+2];
`else
  logic unused_upper_addr;
  assign unused_upper_addr = ^req_addr[B_WIDTH-1:MEM_SIZE+2];
  assign out_of_range      = 1'b0;
`endif

  logic req_err;
  always_comb begin
    req_err = out_of_range;
    case (req_funct3)
      3'b000:  req_err = out_of_range;
      3'b001:  req_err = out_of_range | req_addr[0];
      3'b010:  req_err = out_of_range | (req_addr[1:0] != 2'b00);
      3'b100:  req_err = out_of_range | req_we;
      3'b101:  req_err = out_of_range | req_we | req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  logic [B_WIDTH/8-1:0] be_d;
  logic [B_WIDTH-1:0]   wdata_d;
  always_comb begin
    be_d    = '1;
    wdata_d = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      default: begin
        be_d    = '1;
        wdata_d = req_wdata;
      end
    endcase
  end

  // Lane select uses the registered byte offset; mem_rdata is valid in WAIT.
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic [B_WIDTH-1:0] ld_data;
  always_comb begin
    ld_byte = mem_rdata[7:0];
    case (addr_q)
      2'b01:   ld_byte = mem_rdata[15:8];
      2'b10:   ld_byte = mem_rdata[23:16];
      2'b11:   ld_byte = mem_rdata[31:24];
      default: ld_byte = mem_rdata[7:0];
    endcase
    ld_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{(B_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(B_WIDTH-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(B_WIDTH-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(B_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      funct3_q       <= '0;
      we_q           <= 1'b0;
      req_ready_q    <= 1'b1;
      resp_valid_q   <= 1'b0;
      resp_err_q     <= 1'b0;
      resp_rdata_q   <= '0;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      mem_addr_q     <= '0;
      be_q           <= '0;
      mem_wdata_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            addr_q      <= req_addr[1:0];
            funct3_q    <= req_funct3;
            we_q        <= req_we;
            mem_addr_q  <= req_addr[MEM_SIZE+1:2];
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else if (req_we) begin
              state_q        <= ACCESS;
              mem_write_en_q <= 1'b1;
              be_q           <= be_d;
              mem_wdata_q    <= wdata_d;
            end else begin
              state_q       <= ACCESS;
              mem_read_en_q <= 1'b1;
            end
          end
        end
        ACCESS: begin
          mem_read_en_q  <= 1'b0;
          mem_write_en_q <= 1'b0;
          be_q           <= '0;
          if (we_q) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end else begin
            state_q <= WAIT;
          end
        end
        WAIT: begin
          state_q      <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= ld_data;
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            req_ready_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;
  assign mem_read_en   = mem_read_en_q;
  assign mem_write_en  = mem_write_en_q;
  assign mem_addr      = mem_addr_q;
  assign write_byte_en = be_q;
  assign mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_mem_lsu_ctrl.sv
// Scoreboard bench for mem_lsu_ctrl with a behavioural single-port memory and an independent reference image.
module tb_mem_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [9:0]  mem_addr;
  logic        mem_read_en, mem_write_en;
  logic [3:0]  write_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  mem_lsu_ctrl #(.B_WIDTH(32), .MEM_SIZE(10)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .write_byte_en(write_byte_en), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  always @(posedge clk) begin
    if (mem_write_en)
      for (int i = 0; i < 4; i++)
        if (write_byte_en[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
    if (mem_read_en) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_rd_en"}, 32'(mem_read_en), 32'd0);
    check({tag, "_wr_en"}, 32'(mem_write_en), 32'd0);
    check({tag, "_be"}, 32'(write_byte_en), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input int hold);
    exp_t        e, g;
    logic        ill, bad_idle, bad_both;
    logic [3:0]  xbe, obs_be;
    logic [31:0] xwd, w, sh, obs_wd;
    logic [9:0]  obs_ad;
    int          lat, nrd, nwr;

    case (f3)
      3'd0:    ill = 1'b0;
      3'd1:    ill = a[0];
      3'd2:    ill = (a[1:0] != 2'b00);
      3'd4:    ill = we;
      3'd5:    ill = we | a[0];
      default: ill = 1'b1;
    endcase
`ifdef MEM_LSU_BOUND_CHK_EN
    if (a[31:12] != 20'd0) ill = 1'b1;
`endif
    case (f3[1:0])
      2'd0:    begin xbe = 4'b0001 << a[1:0]; xwd = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
      2'd1:    begin xbe = a[1] ? 4'b1100 : 4'b0011; xwd = {wd[15:0], wd[15:0]}; end
      default: begin xbe = 4'b1111; xwd = wd; end
    endcase

    w  = ref_mem[a[11:2]];
    sh = w >> {a[1:0], 3'b000};
    e.err = ill;
    e.lat = ill ? 1 : (we ? 2 : 3);
    if (ill || we) e.rdata = 32'd0;
    else case (f3)
      3'd0:    e.rdata = {{24{sh[7]}}, sh[7:0]};
      3'd1:    e.rdata = {{16{sh[15]}}, sh[15:0]};
      3'd4:    e.rdata = {24'd0, sh[7:0]};
      3'd5:    e.rdata = {16'd0, sh[15:0]};
      default: e.rdata = w;
    endcase
    if (!ill && we)
      for (int i = 0; i < 4; i++)
        if (xbe[i]) ref_mem[a[11:2]][8*i +: 8] = xwd[8*i +: 8];
    sb_q.push_back(e);

    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    resp_ready = (hold == 0);
    lat = 0; nrd = 0; nwr = 0;
    bad_idle = 1'b0; bad_both = 1'b0;
    obs_be = 4'd0; obs_wd = 32'd0; obs_ad = 10'd0;

    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (mem_read_en) begin nrd++; obs_ad = mem_addr; end
      if (mem_write_en) begin
        nwr++; obs_ad = mem_addr; obs_be = write_byte_en; obs_wd = mem_wdata;
      end else if (write_byte_en != 4'd0) bad_idle = 1'b1;
      if (mem_read_en && mem_write_en) bad_both = 1'b1;
      if (resp_valid) lat = k;
    end

    g = sb_q.pop_front();
    check("latency", 32'(lat), 32'(g.lat));
    check("n_read", 32'(nrd), (!ill && !we) ? 32'd1 : 32'd0);
    check("n_write", 32'(nwr), (!ill && we) ? 32'd1 : 32'd0);
    check("be_idle", 32'(bad_idle), 32'd0);
    check("rd_wr_overlap", 32'(bad_both), 32'd0);
    if (!ill) check("mem_addr", 32'(obs_ad), 32'(a[11:2]));
    if (!ill && we) begin
      check("wr_be", 32'(obs_be), 32'(xbe));
      check("wr_data", obs_wd, xwd);
    end
    check("rdata", resp_rdata, g.rdata);
    check("err", 32'(resp_err), 32'(g.err));

    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_rdata", resp_rdata, g.rdata);
      check("hold_err", 32'(resp_err), 32'(g.err));
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("post_valid", 32'(resp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ftab [0:4];
    logic       seen;
    ftab[0] = 3'd0; ftab[1] = 3'd1; ftab[2] = 3'd2; ftab[3] = 3'd4; ftab[4] = 3'd5;
    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 32'd0;
      ref_mem[i] = 32'd0;
    end
    mem_rdata  = 32'd0;
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    resp_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    check_reset("rst");
    rst = 1'b0;

    // Load accepted, then reset lands while it sits in ACCESS.
    req_valid  = 1'b1;
    req_funct3 = 3'd2;
    req_addr   = 32'h10;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midload_rd_en", 32'(mem_read_en), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("midrst");
    rst  = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    check("midrst_no_resp", 32'(seen), 32'd0);

    do_req(1'b1, 3'd2, 32'h20, 32'hDEADBEEF, 0);
    do_req(1'b0, 3'd2, 32'h20, 32'd0, 0);
    do_req(1'b1, 3'd0, 32'h23, 32'h00000080, 0);
    do_req(1'b0, 3'd0, 32'h23, 32'd0, 0);
    do_req(1'b0, 3'd4, 32'h23, 32'd0, 0);
    do_req(1'b1, 3'd1, 32'h26, 32'h0000C3A5, 0);
    do_req(1'b0, 3'd1, 32'h26, 32'd0, 0);

    do_req(1'b0, 3'd1, 32'h21, 32'd0, 0);
    do_req(1'b1, 3'd2, 32'h22, 32'h11111111, 0);
    do_req(1'b1, 3'd4, 32'h20, 32'h22222222, 0);
    do_req(1'b0, 3'd3, 32'h20, 32'd0, 0);

    do_req(1'b1, 3'd2, 32'h20, 32'h1234ABCD, 0);
    do_req(1'b0, 3'd5, 32'h22, 32'd0, 5);

    do_req(1'b1, 3'd2, 32'h0, 32'hCAFEF00D, 0);
    do_req(1'b0, 3'd2, 32'h1000, 32'd0, 0);

    for (int n = 0; n < 30; n++)
      do_req(1'($urandom_range(0, 1)), ftab[$urandom_range(0, 4)],
             32'h40 + 32'($urandom_range(0, 31)), $urandom, $urandom_range(0, 2));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
